// File: rtl/fixed_point_alu_arbiter.sv
// fixed_point_alu_arbiter
//
// Shares one fixed-point ALU between two requesters (r0, r1). A requester
// raises rN_req with its opcode and operands and holds them until its
// rN_done pulse. The arbiter grants round-robin, latches the winner's
// operands, pulses alu_start, waits for alu_done and hands the registered
// result back to the winner only. A watchdog aborts an ALU operation that
// never completes and reports it through rN_error.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   rN_req                     level request from requester N
//   rN_op / rN_a / rN_b        opcode and operands from requester N
//   rN_done                    one-cycle completion pulse to requester N
//   rN_result / rN_error       registered result / timeout flag, held until
//                              requester N's next completion
//   alu_start                  one-cycle start pulse to the ALU
//   alu_op / alu_a / alu_b     registered opcode and operands to the ALU
//   alu_done / alu_result      completion pulse and result from the ALU
module fixed_point_alu_arbiter #(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int TIMEOUT_CYCLES        = 64,
  localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    r0_req,
  input  logic [2:0]              r0_op,
  input  logic [NUMBER_WIDTH-1:0] r0_a,
  input  logic [NUMBER_WIDTH-1:0] r0_b,
  output logic                    r0_done,
  output logic [NUMBER_WIDTH-1:0] r0_result,
  output logic                    r0_error,

  input  logic                    r1_req,
  input  logic [2:0]              r1_op,
  input  logic [NUMBER_WIDTH-1:0] r1_a,
  input  logic [NUMBER_WIDTH-1:0] r1_b,
  output logic                    r1_done,
  output logic [NUMBER_WIDTH-1:0] r1_result,
  output logic                    r1_error,

  output logic                    alu_start,
  input  logic                    alu_done,
  output logic [2:0]              alu_op,
  output logic [NUMBER_WIDTH-1:0] alu_a,
  output logic [NUMBER_WIDTH-1:0] alu_b,
  input  logic [NUMBER_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  // The watchdog fires while the counter holds TIMEOUT_CYCLES-1, i.e. on the
  // TIMEOUT_CYCLES-th cycle spent in WAIT. A zero setting disables it.
  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [15:0] timeout_count;

  logic        any_req;
  logic        pick;

  // Round-robin pick: a lone requester wins outright; on a tie the requester
  // that was not served last wins.
  always_comb begin
    any_req = r0_req | r1_req;
    pick    = 1'b0;
    if (r0_req && r1_req) begin
      pick = ~last_grant;
    end else if (r1_req) begin
      pick = 1'b1;
    end
  end

  // Main sequencer. alu_start and rN_done are set on the transition into
  // START/DONE and cleared by default, so each is high for exactly one cycle
  // while the state register sits in START/DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      timeout_count <= '0;
      alu_start     <= 1'b0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      r0_done       <= 1'b0;
      r0_result     <= '0;
      r0_error      <= 1'b0;
      r1_done       <= 1'b0;
      r1_result     <= '0;
      r1_error      <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            alu_op     <= pick ? r1_op : r0_op;
            alu_a      <= pick ? r1_a  : r0_a;
            alu_b      <= pick ? r1_b  : r0_b;
            alu_start  <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          timeout_count <= '0;
          state         <= WAIT;
        end

        WAIT: begin
          // A real completion beats a watchdog expiry in the same cycle.
          if (alu_done) begin
            if (grant) begin
              r1_result <= alu_result;
              r1_error  <= 1'b0;
              r1_done   <= 1'b1;
            end else begin
              r0_result <= alu_result;
              r0_error  <= 1'b0;
              r0_done   <= 1'b1;
            end
            state <= DONE;
          end else if (TIMEOUT_EN && (timeout_count == TIMEOUT_LAST)) begin
            if (grant) begin
              r1_result <= '0;
              r1_error  <= 1'b1;
              r1_done   <= 1'b1;
            end else begin
              r0_result <= '0;
              r0_error  <= 1'b1;
              r0_done   <= 1'b1;
            end
            state <= DONE;
          end else begin
            timeout_count <= timeout_count + 16'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
